// File: rtl/sha256_msg_schedule_pkg.sv
// sha256_msg_schedule_pkg: shared widths, sigma amounts, state encodings and rotate helper
package sha256_msg_schedule_pkg;
  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;
  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;
  typedef enum logic {ST_LOAD = 1'b0, ST_EMIT = 1'b1} state_t;
  function automatic logic [WORD_W-1:0] right_cyclic_shift(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
endpackage

// File: rtl/sha256_small_sigma.sv
// sha256_small_sigma: combinational ROTR(R1) ^ ROTR(R2) ^ SHR(SH)
module sha256_small_sigma
  import sha256_msg_schedule_pkg::*;
#(
  parameter int R1 = S0_R1,
  parameter int R2 = S0_R2,
  parameter int SH = S0_SH
) (
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_y
);
  assign o_y = right_cyclic_shift(i_x, R1) ^ right_cyclic_shift(i_x, R2) ^ (i_x >> SH);
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: loads 16 message words, streams the 64-word schedule from a 16-slot ring
module sha256_msg_schedule
  import sha256_msg_schedule_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_word,
  output logic [5:0]        w_index,
  output logic              w_last
);
  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt;
  logic [6:0]        r_t;
  logic [WORD_W-1:0] r_buf [16];
  logic [3:0]        w_idx;
  logic [WORD_W-1:0] w_s0, w_s1, w_sum, w_next;
  logic              w_in_fire, w_last_in, w_load, w_out_fire;

  assign w_idx      = r_t[3:0];
  assign in_ready   = (r_state == ST_LOAD);
  assign w_in_fire  = in_valid && in_ready;
  assign w_last_in  = w_in_fire && (r_cnt == 4'd15);
  // r_t is 0 throughout LOAD, so the final input handshake loads W0 from the ring directly
  assign w_load     = w_last_in || (r_state == ST_EMIT && !r_t[6] && (!w_valid || w_ready));
  assign w_out_fire = w_valid && w_ready && w_last;

  sha256_small_sigma #(.R1(S0_R1), .R2(S0_R2), .SH(S0_SH)) u_s0 (
    .i_x(r_buf[w_idx + 4'd1]),
    .o_y(w_s0)
  );
  sha256_small_sigma #(.R1(S1_R1), .R2(S1_R2), .SH(S1_SH)) u_s1 (
    .i_x(r_buf[w_idx - 4'd2]),
    .o_y(w_s1)
  );

  assign w_sum  = w_s1 + r_buf[w_idx - 4'd7] + w_s0 + r_buf[w_idx];
  assign w_next = (r_t >= 7'd16) ? w_sum : r_buf[w_idx];

  always_comb begin
    w_state_nxt = w_last_in ? ST_EMIT : w_out_fire ? ST_LOAD : r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
      r_t     <= '0;
      w_valid <= 1'b0;
      w_word  <= '0;
      w_index <= '0;
      w_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_fire) r_cnt <= r_cnt + 4'd1;
      if (w_load) begin
        w_word  <= w_next;
        w_index <= r_t[5:0];
        w_last  <= (r_t == 7'(ROUNDS - 1));
        w_valid <= 1'b1;
        r_t     <= r_t + 7'd1;
      end else if (w_ready) begin
        w_valid <= 1'b0;
      end
      if (w_out_fire) begin
        r_t    <= '0;
        w_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_buf[r_cnt] <= in_word;
    else if (w_load && r_t >= 7'd16) r_buf[w_idx] <= w_sum;
  end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: directed blocks checked against hand values and a reference schedule
module tb_sha256_msg_schedule;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, w_ready = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_ready, w_valid, w_last;
  logic [31:0] w_word;
  logic [5:0]  w_index;
  int          n_chk = 0, n_err = 0;
  logic [31:0] blk [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  sha256_msg_schedule dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .w_valid(w_valid), .w_ready(w_ready), .w_word(w_word), .w_index(w_index), .w_last(w_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    for (int i = 0; i < 64; i++) exp_w[i] = (i < 16) ? blk[i] : 32'h0;
    for (int i = 16; i < 64; i++) exp_w[i] = ss1(exp_w[i-2]) + exp_w[i-7] + ss0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic set_ones();
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    for (int i = 0; i < 64; i++) exp_w[i] = (i < 16) ? blk[i] : 32'h0;
    for (int i = 16; i < 64; i++) exp_w[i] = ss1(exp_w[i-2]) + exp_w[i-7] + ss0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic send_block(input bit gaps);
    int i = 0, g = 0;
    while (i < 16 && g < 400) begin
      @(negedge clk);
      g++;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_word  = in_valid ? blk[i] : 32'hDEADBEEF;
      if (in_valid && in_ready) i++;
    end
    chk("load_count", 32'(i), 32'd16);
  endtask

  task automatic collect(input bit bp, input bit hold, input int stop_at);
    int k = 0, cyc = 0;
    bit prev_stall = 1'b0;
    logic [31:0] pw = '0;
    logic [5:0]  pi = '0;
    while (k < stop_at && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        in_valid = hold;
        in_word  = 32'hBADC0FFE;
        chk("w0_latency", {31'b0, w_valid}, 32'd1);
      end
      w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("in_ready_emit", {31'b0, in_ready}, 32'd0);
      chk("valid_emit", {31'b0, w_valid}, 32'd1);
      if (prev_stall) begin
        chk("stall_word", w_word, pw);
        chk("stall_idx", {26'b0, w_index}, {26'b0, pi});
      end
      if (w_valid && w_ready) begin
        chk($sformatf("idx%0d", k), {26'b0, w_index}, 32'(k));
        chk($sformatf("w%0d", k), w_word, exp_w[k]);
        chk($sformatf("last%0d", k), {31'b0, w_last}, {31'b0, k == 63});
        got_w[k] = w_word;
        k++;
        if (k == 64) in_valid = 1'b0;
      end
      prev_stall = w_valid && !w_ready;
      pw = w_word;
      pi = w_index;
    end
    chk("emit_count", 32'(k), 32'(stop_at));
    if (stop_at == 64) begin
      if (!bp) chk("emit_cycles", 32'(cyc), 32'd64);
      @(negedge clk);
      #1;
      chk("in_ready_after", {31'b0, in_ready}, 32'd1);
      chk("valid_after", {31'b0, w_valid}, 32'd0);
    end
  endtask

  initial begin
    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, w_valid}, 32'd0);
    chk("rst_word", w_word, 32'd0);
    chk("rst_index", {26'b0, w_index}, 32'd0);
    chk("rst_last", {31'b0, w_last}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    set_abc();
    send_block(1'b0);
    collect(1'b0, 1'b0, 64);
    chk("abc_w0", got_w[0], 32'h61626380);
    chk("abc_w15", got_w[15], 32'h00000018);
    chk("abc_w16", got_w[16], 32'h61626380);
    chk("abc_w17", got_w[17], 32'h000F0000);
    chk("abc_w18", got_w[18], 32'h7DA86405);
    chk("abc_w19", got_w[19], 32'h600003C6);

    send_block(1'b0);
    collect(1'b1, 1'b0, 64);

    set_ones();
    send_block(1'b0);
    collect(1'b0, 1'b0, 64);
    chk("ones_w16", got_w[16], 32'h203FFFFC);
    chk("ones_w17", got_w[17], 32'h203FFFFC);

    set_abc();
    send_block(1'b1);
    collect(1'b0, 1'b1, 64);

    send_block(1'b0);
    collect(1'b0, 1'b0, 30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, w_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_index", {26'b0, w_index}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ones();
    send_block(1'b0);
    collect(1'b0, 1'b0, 64);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
